// File: rtl/eth_hdr_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// eth_hdr_frame_tx_pkg
// Shared definitions for the Ethernet transmit frame builder and the reusable
// AXI-stream output register:
//   - header length and field widths
//   - FSM state encoding (IDLE=0, HEADER=1, PAYLOAD=2)
//   - hdr_byte(): picks byte <idx> (MSB first) out of a packed header
// -----------------------------------------------------------------------------
package eth_hdr_frame_tx_pkg;

   localparam int ETH_HDR_LEN = 14;
   localparam int ETH_MAC_W   = 48;
   localparam int ETH_TYPE_W  = 16;
   localparam int ETH_HDR_W   = 2 * ETH_MAC_W + ETH_TYPE_W;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   // Header is packed {dest, src, type}, so byte 0 is the top byte. Shifting
   // left by 8*idx brings the wanted byte to the top.
   function automatic logic [7:0] hdr_byte(input logic [ETH_HDR_W-1:0] hdr,
                                           input logic [3:0]           idx);
      logic [ETH_HDR_W-1:0] sh;
      sh = hdr << {idx, 3'b000};
      return sh[ETH_HDR_W-1 -: 8];
   endfunction

endpackage

// File: rtl/eth_hdr_frame_tx_axis_out_reg.sv
// -----------------------------------------------------------------------------
// eth_axis_out_reg
// Registered AXI-stream stage with one skid entry. It carries tdata/tlast/tuser.
// It runs at full throughput, and s_tready is driven straight from a flop.
//
// Handshake: a beat moves on the rising clock edge when valid && ready are both
// high. A producer keeps valid and payload stable until that edge. m_tvalid is
// never withdrawn while m_tready is low.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   s_tdata/tvalid/tready/tlast/tuser   upstream beat
//   m_tdata/tvalid/tready/tlast/tuser   downstream beat
// -----------------------------------------------------------------------------
module eth_axis_out_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic              s_tlast,
   input  logic              s_tuser,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              m_tuser
);

   logic [DATA_W+1:0] out_q, skid_q, in_beat;
   logic              out_vld, skid_vld, rdy_q;
   logic              out_vld_nxt, skid_vld_nxt, rdy_nxt;
   logic              in_to_out, in_to_skid, skid_to_out;

   assign in_beat = {s_tlast, s_tuser, s_tdata};

   // While rdy_q is high the skid entry is always empty. Ready stays high if
   // the output drains this cycle, or if nothing can land in the skid entry.
   always_comb begin
      out_vld_nxt  = out_vld;
      skid_vld_nxt = skid_vld;
      in_to_out    = 1'b0;
      in_to_skid   = 1'b0;
      skid_to_out  = 1'b0;
      rdy_nxt      = m_tready || (!skid_vld && (!out_vld || !s_tvalid));
      if (rdy_q) begin
         if (m_tready || !out_vld) begin
            out_vld_nxt = s_tvalid;
            in_to_out   = 1'b1;
         end else begin
            skid_vld_nxt = s_tvalid;
            in_to_skid   = 1'b1;
         end
      end else if (m_tready) begin
         out_vld_nxt  = skid_vld;
         skid_vld_nxt = 1'b0;
         skid_to_out  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q    <= '0;
         skid_q   <= '0;
         out_vld  <= 1'b0;
         skid_vld <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         out_vld  <= out_vld_nxt;
         skid_vld <= skid_vld_nxt;
         rdy_q    <= rdy_nxt;
         if (in_to_out) begin
            out_q <= in_beat;
         end else if (skid_to_out) begin
            out_q <= skid_q;
         end
         if (in_to_skid) begin
            skid_q <= in_beat;
         end
      end
   end

   assign s_tready = rdy_q;
   assign m_tvalid = out_vld;
   assign m_tdata  = out_q[DATA_W-1:0];
   assign m_tuser  = out_q[DATA_W];
   assign m_tlast  = out_q[DATA_W+1];

endmodule

// File: rtl/eth_hdr_frame_tx.sv
// -----------------------------------------------------------------------------
// eth_hdr_frame_tx
// Builds one byte stream per frame for the MAC transmit AXI-stream input. Each
// frame is 14 header bytes (dest MAC, src MAC, EtherType, MSB first) followed by
// the payload stream passed through unchanged. Preamble, SFD, padding and FCS
// are added by the MAC.
//
// Optional statistics counters are compiled in with the macro
// ETH_HDR_FRAME_TX_STATS_EN. Without the macro, both stat outputs are tied to 0.
//
// Handshake: a beat or header moves on the rising clock edge when valid &&
// ready are both high. Producers hold valid and data stable until that edge.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_eth_hdr_*              parallel header (valid/ready, dest/src MAC, type)
//   s_axis_payload_*         8-bit payload stream; tuser counts only with tlast
//   m_axis_*                 serialized frame bytes to the MAC
//   busy                     a frame is being built
//   stat_tx_frames/bytes     output tlast transfers / all output transfers
//   dbg_state                current FSM state
// -----------------------------------------------------------------------------
module eth_hdr_frame_tx
   import eth_hdr_frame_tx_pkg::*;
#(
   parameter int STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_eth_hdr_valid,
   output logic                  s_eth_hdr_ready,
   input  logic [ETH_MAC_W-1:0]  s_eth_dest_mac,
   input  logic [ETH_MAC_W-1:0]  s_eth_src_mac,
   input  logic [ETH_TYPE_W-1:0] s_eth_type,
   input  logic [7:0]            s_axis_payload_tdata,
   input  logic                  s_axis_payload_tvalid,
   output logic                  s_axis_payload_tready,
   input  logic                  s_axis_payload_tlast,
   input  logic                  s_axis_payload_tuser,
   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  busy,
   output logic [STAT_WIDTH-1:0] stat_tx_frames,
   output logic [STAT_WIDTH-1:0] stat_tx_bytes,
   output logic [1:0]            dbg_state
);

   state_t               state, state_nxt;
   logic [3:0]           hdr_idx, hdr_idx_nxt;
   logic [ETH_HDR_W-1:0] hdr_q;
   logic                 hdr_fire;
   logic                 reg_ready;
   logic [7:0]           in_data;
   logic                 in_valid, in_last, in_user;

   // A header is taken only when the output stage can take byte 0 on the same
   // edge. That gives the one-cycle header-to-first-byte latency.
   assign s_eth_hdr_ready       = (state == ST_IDLE) && reg_ready;
   assign hdr_fire              = s_eth_hdr_valid && s_eth_hdr_ready;
   assign s_axis_payload_tready = (state == ST_PAYLOAD) && reg_ready;
   assign busy                  = (state != ST_IDLE);
   assign dbg_state             = state;

   always_comb begin
      state_nxt   = state;
      hdr_idx_nxt = hdr_idx;
      in_data     = '0;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      in_user     = 1'b0;
      case (state)
         ST_IDLE: begin
            // Byte 0 comes straight from the input port on the accepting edge.
            in_data  = s_eth_dest_mac[ETH_MAC_W-1 -: 8];
            in_valid = hdr_fire;
            if (hdr_fire) begin
               hdr_idx_nxt = 4'd1;
               state_nxt   = ST_HEADER;
            end
         end
         ST_HEADER: begin
            in_data  = hdr_byte(hdr_q, hdr_idx);
            in_valid = 1'b1;
            if (reg_ready) begin
               if (hdr_idx == 4'(ETH_HDR_LEN - 1)) begin
                  hdr_idx_nxt = '0;
                  state_nxt   = ST_PAYLOAD;
               end else begin
                  hdr_idx_nxt = hdr_idx + 4'd1;
               end
            end
         end
         ST_PAYLOAD: begin
            in_data  = s_axis_payload_tdata;
            in_valid = s_axis_payload_tvalid;
            in_last  = s_axis_payload_tlast;
            // The abort flag is meaningful only on the closing beat.
            in_user  = s_axis_payload_tlast && s_axis_payload_tuser;
            if (s_axis_payload_tvalid && reg_ready && s_axis_payload_tlast) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         hdr_idx <= '0;
         hdr_q   <= '0;
      end else begin
         state   <= state_nxt;
         hdr_idx <= hdr_idx_nxt;
         if (hdr_fire) begin
            hdr_q <= {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
         end
      end
   end

   eth_axis_out_reg #(
      .DATA_W (8)
   ) u_out_reg (
      .clk      (clk),
      .rst      (rst),
      .s_tdata  (in_data),
      .s_tvalid (in_valid),
      .s_tready (reg_ready),
      .s_tlast  (in_last),
      .s_tuser  (in_user),
      .m_tdata  (m_axis_tdata),
      .m_tvalid (m_axis_tvalid),
      .m_tready (m_axis_tready),
      .m_tlast  (m_axis_tlast),
      .m_tuser  (m_axis_tuser)
   );

`ifdef ETH_HDR_FRAME_TX_STATS_EN
   logic [STAT_WIDTH-1:0] frames_q, bytes_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frames_q <= '0;
         bytes_q  <= '0;
      end else if (m_axis_tvalid && m_axis_tready) begin
         bytes_q <= bytes_q + STAT_WIDTH'(1);
         if (m_axis_tlast) begin
            frames_q <= frames_q + STAT_WIDTH'(1);
         end
      end
   end

   assign stat_tx_frames = frames_q;
   assign stat_tx_bytes  = bytes_q;
`else
   assign stat_tx_frames = '0;
   assign stat_tx_bytes  = '0;
`endif

endmodule

// File: tb/tb_eth_hdr_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_eth_hdr_frame_tx
// Bench for eth_hdr_frame_tx. Each frame is described once at the field level.
// The expected byte stream is built from those fields, and the drivers feed the
// same description to the DUT. A negedge monitor compares every output transfer
// against the expected queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_eth_hdr_frame_tx;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- DUT ----------------
   logic        s_eth_hdr_valid = 1'b0;
   logic        s_eth_hdr_ready;
   logic [47:0] s_eth_dest_mac = '0;
   logic [47:0] s_eth_src_mac = '0;
   logic [15:0] s_eth_type = '0;
   logic [7:0]  p_data = '0;
   logic        p_valid = 1'b0;
   logic        s_axis_payload_tready;
   logic        p_last = 1'b0;
   logic        p_user = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        busy;
   logic [31:0] stat_tx_frames;
   logic [31:0] stat_tx_bytes;
   logic [1:0]  dbg_state;

   eth_hdr_frame_tx #(.STAT_WIDTH(32)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .s_eth_hdr_valid       (s_eth_hdr_valid),
      .s_eth_hdr_ready       (s_eth_hdr_ready),
      .s_eth_dest_mac        (s_eth_dest_mac),
      .s_eth_src_mac         (s_eth_src_mac),
      .s_eth_type            (s_eth_type),
      .s_axis_payload_tdata  (p_data),
      .s_axis_payload_tvalid (p_valid),
      .s_axis_payload_tready (s_axis_payload_tready),
      .s_axis_payload_tlast  (p_last),
      .s_axis_payload_tuser  (p_user),
      .m_axis_tdata          (m_axis_tdata),
      .m_axis_tvalid         (m_axis_tvalid),
      .m_axis_tready         (m_axis_tready),
      .m_axis_tlast          (m_axis_tlast),
      .m_axis_tuser          (m_axis_tuser),
      .busy                  (busy),
      .stat_tx_frames        (stat_tx_frames),
      .stat_tx_bytes         (stat_tx_bytes),
      .dbg_state             (dbg_state)
   );

   // ---------------- check / counters ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Beat layout in both queues: {tlast, tuser, tdata}
   logic [9:0] exp_q[$];
   logic [9:0] drv_q[$];
   int         mdl_bytes = 0;
   int         mdl_frames = 0;

   function automatic logic [7:0] model_hdr_byte(input logic [47:0] d, input logic [47:0] s,
                                                 input logic [15:0] t, input int i);
      if (i < 6)       return 8'(d >> (8 * (5 - i)));
      else if (i < 12) return 8'(s >> (8 * (11 - i)));
      else             return 8'(t >> (8 * (13 - i)));
   endfunction

   function automatic logic [31:0] exp_stat(input int v);
`ifdef ETH_HDR_FRAME_TX_STATS_EN
      return 32'(v);
`else
      return 32'(0 * v);
`endif
   endfunction

   // dmode: 0 random bytes, 1 sequential 0,1,2..., 2 constant 0xAA
   task automatic build_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input logic last_user, input int dmode);
      logic [7:0] b;
      logic       u, l;
      for (int i = 0; i < 14; i++) exp_q.push_back({2'b00, model_hdr_byte(d, s, t, i)});
      for (int i = 0; i < len; i++) begin
         b = (dmode == 1) ? 8'(i) : (dmode == 2) ? 8'hAA : 8'($urandom_range(0, 255));
         l = (i == len - 1);
         u = l ? last_user : 1'($urandom_range(0, 1));
         drv_q.push_back({l, u, b});
         exp_q.push_back({l, l & last_user, b});
      end
      mdl_bytes  += 14 + len;
      mdl_frames += 1;
   endtask

   // ---------------- output ready pattern ----------------
   int rdy_mode = 0;  // 0: always 1, 1: 1,0,0,1 repeating, 2: random
   int rdy_ph = 0;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_axis_tready = 1'b1;
         1: begin
            m_axis_tready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3);
            rdy_ph++;
         end
         default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- monitor / scoreboard ----------------
   int         frame_pos = 0;
   int         xfer_cyc[$];
   logic       prev_stall = 1'b0;
   logic [9:0] prev_beat = '0;
   logic       prev_ptready = 1'b0;
   logic       chk_pay_rise = 1'b0;
   logic [9:0] beat;
   logic [9:0] expv;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall   = 1'b0;
         prev_ptready = 1'b0;
      end else begin
         beat = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
         if (chk_pay_rise && s_axis_payload_tready && !prev_ptready)
            check("pay_ready_after_hdr", 32'(frame_pos), 32'd13);
         prev_ptready = s_axis_payload_tready;
         if (prev_stall) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_beat", 32'(beat), 32'(prev_beat));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            xfer_cyc.push_back(cyc);
            check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               expv = exp_q.pop_front();
               check("out_beat", 32'(beat), 32'(expv));
            end
            frame_pos = m_axis_tlast ? 0 : frame_pos + 1;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = beat;
      end
   end

   // ---------------- drivers ----------------
   bit abort = 1'b0;
   int hdr_acc_cyc = 0;
   int pay_last_cyc = 0;

   task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
      int g = 0;
      s_eth_dest_mac  = d;
      s_eth_src_mac   = s;
      s_eth_type      = t;
      s_eth_hdr_valid = 1'b1;
      do begin @(negedge clk); g++; end while (!s_eth_hdr_ready && g < 400 && !abort);
      if (!abort) begin
         if (!s_eth_hdr_ready) check("hdr_timeout", 32'(s_eth_hdr_ready), 32'd1);
         else begin
            hdr_acc_cyc = cyc + 1;
            @(posedge clk); #1;
         end
      end
      s_eth_hdr_valid = 1'b0;
   endtask

   task automatic send_payload(input bit gap);
      logic [9:0] it;
      int g;
      while (drv_q.size() != 0 && !abort) begin
         it = drv_q[0];
         if (gap && $urandom_range(0, 2) == 0) begin
            p_valid = 1'b0;
            @(posedge clk); #1;
         end
         p_data = it[7:0]; p_user = it[8]; p_last = it[9]; p_valid = 1'b1;
         g = 0;
         do begin @(negedge clk); g++; end while (!s_axis_payload_tready && g < 400 && !abort);
         if (abort) break;
         if (!s_axis_payload_tready) begin
            check("pay_timeout", 32'(s_axis_payload_tready), 32'd1);
            drv_q.delete();
            break;
         end
         if (it[9]) pay_last_cyc = cyc + 1;
         void'(drv_q.pop_front());
         @(posedge clk); #1;
      end
      p_valid = 1'b0; p_last = 1'b0; p_user = 1'b0;
   endtask

   task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int len, input logic lu, input int dmode,
                            input bit gap, input int hdr_dly);
      build_frame(d, s, t, len, lu, dmode);
      fork
         begin
            if (hdr_dly > 0) begin repeat (hdr_dly) @(posedge clk); #1; end
            send_hdr(d, s, t);
         end
         send_payload(gap);
      join
   endtask

   task automatic wait_drain(input int budget);
      int g = 0;
      while (exp_q.size() != 0 && g < budget) begin @(negedge clk); g++; end
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   task automatic check_stats(input string tag);
      check({tag, "_bytes"}, stat_tx_bytes, exp_stat(mdl_bytes));
      check({tag, "_frames"}, stat_tx_frames, exp_stat(mdl_frames));
   endtask

   // ---------------- stimulus ----------------
   localparam logic [47:0] DST1 = 48'h01_02_03_04_05_06;
   localparam logic [47:0] SRC1 = 48'h0A_0B_0C_0D_0E_0F;

   initial begin
      int g;
      int last_a;
      logic [47:0] rd, rs;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst_hdr_ready", 32'(s_eth_hdr_ready), 32'd0);
      check("rst_pay_ready", 32'(s_axis_payload_tready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tdata", 32'(m_axis_tdata), 32'd0);
      check_stats("rst_stat");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("hdr_ready_post_rst", 32'(s_eth_hdr_ready), 32'd1);

      // 1: 60-byte frame, tready held high
      rdy_mode = 0;
      xfer_cyc.delete();
      run_frame(DST1, SRC1, 16'h0800, 46, 1'b0, 1, 1'b0, 0);
      wait_drain(300);
      check("t1_len", 32'(xfer_cyc.size()), 32'd60);
      if (xfer_cyc.size() == 60) begin
         check("t1_first_lat", 32'(xfer_cyc[0]), 32'(hdr_acc_cyc));
         check("t1_no_gap", 32'(xfer_cyc[59] - xfer_cyc[0]), 32'd59);
      end
      check_stats("t1_stat");

      // 2: same frame, tready 1,0,0,1
      rdy_mode = 1; rdy_ph = 0;
      run_frame(DST1, SRC1, 16'h0800, 46, 1'b0, 1, 1'b0, 0);
      wait_drain(600);
      check_stats("t2_stat");

      // 3: back-to-back 15-byte frames
      rdy_mode = 0;
      repeat (4) @(posedge clk);
      #1;
      xfer_cyc.delete();
      run_frame(DST1, SRC1, 16'h88B5, 1, 1'b0, 2, 1'b0, 0);
      last_a = pay_last_cyc;
      run_frame(SRC1, DST1, 16'h88B5, 1, 1'b0, 2, 1'b0, 0);
      check("t3_hdr_after_last", 32'(hdr_acc_cyc - last_a), 32'd1);
      wait_drain(200);
      check("t3_len", 32'(xfer_cyc.size()), 32'd30);
      if (xfer_cyc.size() == 30)
         check("t3_no_gap", 32'(xfer_cyc[29] - xfer_cyc[0]), 32'd29);

      // 4: payload valid before header
      chk_pay_rise = 1'b1;
      run_frame(48'h1111_2222_3333, 48'h4444_5555_6666, 16'h86DD, 8, 1'b0, 0, 1'b0, 5);
      wait_drain(200);
      chk_pay_rise = 1'b0;

      // 5: tuser on the last beat
      run_frame(DST1, SRC1, 16'h0806, 10, 1'b1, 0, 1'b0, 0);
      wait_drain(200);

      // 6: random frames under random backpressure and payload gaps
      rdy_mode = 2;
      for (int f = 0; f < 6; f++) begin
         rd = {$urandom, $urandom};
         rs = {$urandom, $urandom};
         run_frame(rd, rs, 16'($urandom), $urandom_range(1, 24), 1'($urandom_range(0, 1)), 0, 1'b1, 0);
      end
      wait_drain(2000);
      check_stats("t6_stat");

      // 7: reset in the middle of the header
      rdy_mode = 0;
      fork
         run_frame(DST1, SRC1, 16'h0800, 20, 1'b0, 1, 1'b0, 0);
      join_none
      g = 0;
      do begin @(negedge clk); g++; end while (frame_pos != 7 && g < 100);
      check("t7_reach_byte7", 32'(frame_pos), 32'd7);
      #2 rst = 1'b1;
      abort = 1'b1;
      #1;
      check("t7_tvalid", 32'(m_axis_tvalid), 32'd0);
      check("t7_tdata", 32'(m_axis_tdata), 32'd0);
      check("t7_tlast", 32'(m_axis_tlast), 32'd0);
      check("t7_busy", 32'(busy), 32'd0);
      check("t7_hdr_ready", 32'(s_eth_hdr_ready), 32'd0);
      check("t7_pay_ready", 32'(s_axis_payload_tready), 32'd0);
      repeat (3) @(posedge clk);
      exp_q.delete(); drv_q.delete();
      frame_pos = 0; mdl_bytes = 0; mdl_frames = 0;
      abort = 1'b0;
      check_stats("t7_stat_rst");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("t7_hdr_ready_post", 32'(s_eth_hdr_ready), 32'd1);
      xfer_cyc.delete();
      run_frame(DST1, SRC1, 16'h0800, 5, 1'b0, 1, 1'b0, 0);
      wait_drain(200);
      check("t7_len", 32'(xfer_cyc.size()), 32'd19);
      check_stats("t7_stat");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
